// File: rtl/press_pkg.sv
// Shared types and sizing helpers for the button gesture classifier.
package press_pkg;

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, WAIT_REL, LONG} press_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Turns debounced press/release pulses into single, double, long and
// auto-repeat gesture events for one button.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic p_edge,
  input  logic n_edge,
  output logic single_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  press_state_t     state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             single_d, double_d, long_d, tick_d;
  logic             p_ok, n_ok;

  // Next state, counter and event decode; simultaneous edges cancel out.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    tick_d   = 1'b0;
    p_ok     = p_edge & ~n_edge;
    n_ok     = n_edge & ~p_edge;

    case (state)
      IDLE: begin
        if (p_ok) state_d = PRESS1;
      end
      PRESS1: begin
        if (n_ok) begin
          state_d = GAP;
        end else if (cnt == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (p_ok) begin
          state_d  = WAIT_REL;
          double_d = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (n_ok) state_d = IDLE;
      end
      LONG: begin
        if (n_ok) begin
          state_d = IDLE;
        end else if (cnt == REPEAT_LAST) begin
          tick_d = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state) cnt_d = '0;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      single_press <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      single_press <= single_d;
      double_press <= double_d;
      long_press   <= long_d;
      repeat_tick  <= tick_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with short timing parameters.
module tb_press_classifier;

  logic clk = 1'b0;
  logic reset;
  logic p_edge, n_edge;
  logic single_press, double_press, long_press, repeat_tick, busy;

  int errors = 0;
  int checks = 0;

  press_classifier #(
    .LONG_CYCLES  (20),
    .GAP_CYCLES   (10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .p_edge      (p_edge),
    .n_edge      (n_edge),
    .single_press(single_press),
    .double_press(double_press),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then check {single,double,long,repeat,busy} 1 after the edge.
  task automatic run_edge(input string tag, input int e, input logic p, input logic n,
                          input logic [4:0] exp_v);
    logic [4:0] obs;
    p_edge = p;
    n_edge = n;
    @(posedge clk);
    #1;
    p_edge = 1'b0;
    n_edge = 1'b0;
    obs = {single_press, double_press, long_press, repeat_tick, busy};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s edge %0d: observed s/d/l/r/b=%b expected %b", tag, e, obs, exp_v);
    end
  endtask

  // Edge numbers are counted from the first stimulus edge (0); -1 means never.
  task automatic gesture(input string tag, input int last,
                         input int p_a, input int p_b, input int n_a, input int n_b,
                         input int s_at, input int d_at, input int l_at,
                         input int r_a, input int r_b, input int busy_last);
    logic [4:0] exp_v;
    for (int e = 0; e <= last; e++) begin
      exp_v = {e == s_at, e == d_at, e == l_at, (e == r_a) || (e == r_b), e <= busy_last};
      run_edge(tag, e, (e == p_a) || (e == p_b), (e == n_a) || (e == n_b), exp_v);
    end
  endtask

  initial begin
    logic [4:0] obs;
    reset  = 1'b1;
    p_edge = 1'b0;
    n_edge = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {single_press, double_press, long_press, repeat_tick, busy};
    checks++;
    assert (obs === 5'b0) else begin
      errors++;
      $error("FAIL reset_state: observed %b expected %b", obs, 5'b0);
    end
    reset = 1'b0;

    //        tag            last p_a p_b n_a n_b  s   d   l  r_a r_b busy_last
    gesture("idle",          3,  -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    gesture("single",       20,   0, -1,  5, -1, 15, -1, -1, -1, -1, 14);
    gesture("double",       55,   0,  8,  3, 50, -1,  8, -1, -1, -1, 49);
    gesture("long_repeat",  40,   0, -1, 32, -1, -1, -1, 20, 25, 30, 31);
    gesture("rel_edge19",   32,   0, -1, 19, -1, 29, -1, -1, -1, -1, 28);
    gesture("rel_terminal", 33,   0, -1, 20, -1, 30, -1, -1, -1, -1, 29);
    gesture("gap_terminal", 20,   0, 15,  5, 18, -1, 15, -1, -1, -1, 17);
    gesture("both_edges",    4,   0, -1,  0, -1, -1, -1, -1, -1, -1, -1);
    gesture("stray_n",       4,  -1, -1,  1, -1, -1, -1, -1, -1, -1, -1);

    // Reset while the single-press gap is running.
    gesture("pre_reset",     7,   0, -1,  5, -1, -1, -1, -1, -1, -1,  7);
    reset = 1'b1;
    #1;
    obs = {single_press, double_press, long_press, repeat_tick, busy};
    checks++;
    assert (obs === 5'b0) else begin
      errors++;
      $error("FAIL async_reset: observed %b expected %b", obs, 5'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    gesture("post_reset",   20,  -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);
    gesture("after_reset",  20,   0, -1,  5, -1, 15, -1, -1, -1, -1, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
